// File: rtl/settle_pkg.sv
// Shared encodings for the settle checker: FSM states, verdict cause codes and
// the latency sentinel reported on timeout.
package settle_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_EARLY   = 2'd1;
    localparam logic [1:0] FC_TIMEOUT = 2'd2;
    localparam logic [1:0] FC_GLITCH  = 2'd3;

    localparam logic [7:0] LAT_TIMEOUT = 8'hFF;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that stops at LIMIT instead of wrapping; clear has priority over inc.
module sat_counter #(
    parameter int W     = 8,
    parameter int LIMIT = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_limit
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    assign at_limit = (count == LIM);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !at_limit) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/settle_checker.sv
// Arms on start, then checks that value is not already EXPECT, reaches it within
// TIMEOUT clocks, and holds it for STABLE clocks; reports verdict, cause and latency.
module settle_checker
    import settle_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] EXPECT  = 4'h5,
    parameter int               TIMEOUT = 15,
    parameter int               STABLE  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [7:0]       latency
);

    state_t     state, state_nx;
    logic       match;
    logic       arm, set_pass, set_fail, lat_load, lat_sentinel;
    logic [1:0] code_nx;
    logic       wait_clr, wait_inc, wait_at_limit;
    logic       hold_clr, hold_inc, hold_at_limit;
    logic [7:0] wait_cnt;
    logic [3:0] hold_cnt;
    logic       unused_hold;

    // An X/Z bit makes this unknown, which every branch below treats as a mismatch.
    assign match = (value == EXPECT);

    sat_counter #(.W(8), .LIMIT(TIMEOUT)) u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (wait_clr),
        .inc      (wait_inc),
        .count    (wait_cnt),
        .at_limit (wait_at_limit)
    );

    sat_counter #(.W(4), .LIMIT(STABLE)) u_hold_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (hold_clr),
        .inc      (hold_inc),
        .count    (hold_cnt),
        .at_limit (hold_at_limit)
    );

    assign unused_hold = ^hold_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_nx     = state;
        arm          = 1'b0;
        set_pass     = 1'b0;
        set_fail     = 1'b0;
        code_nx      = FC_NONE;
        lat_load     = 1'b0;
        lat_sentinel = 1'b0;
        wait_clr     = 1'b0;
        wait_inc     = 1'b0;
        hold_clr     = 1'b0;
        hold_inc     = 1'b0;
        case (state)
            IDLE: begin
                wait_clr = 1'b1;
                hold_clr = 1'b1;
                if (start) begin
                    arm      = 1'b1;
                    state_nx = ARM;
                end
            end
            ARM: begin
                if (match) begin
                    set_fail = 1'b1;
                    code_nx  = FC_EARLY;
                    state_nx = DONE;
                end else begin
                    wait_inc = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (match) begin
                    lat_load = 1'b1;
                    hold_inc = 1'b1;
                    state_nx = HOLD;
                end else if (wait_at_limit) begin
                    set_fail     = 1'b1;
                    code_nx      = FC_TIMEOUT;
                    lat_sentinel = 1'b1;
                    state_nx     = DONE;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            HOLD: begin
                if (match) begin
                    if (hold_at_limit) begin
                        set_pass = 1'b1;
                        state_nx = DONE;
                    end else begin
                        hold_inc = 1'b1;
                    end
                end else begin
                    set_fail = 1'b1;
                    code_nx  = FC_GLITCH;
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Verdict registers stay sticky until the next accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= FC_NONE;
            latency   <= '0;
        end else if (arm) begin
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= FC_NONE;
            latency   <= '0;
        end else begin
            if (lat_load)     latency <= wait_cnt;
            if (lat_sentinel) latency <= LAT_TIMEOUT;
            if (set_pass)     pass    <= 1'b1;
            if (set_fail) begin
                fail      <= 1'b1;
                fail_code <= code_nx;
            end
        end
    end

    assign busy = (state == ARM) || (state == WAIT) || (state == HOLD);
    assign done = (state == DONE);

endmodule

// File: doc/settle_checker.md
Name: settle_checker

Overview:
- Downstream monitor for a register driven by a delayed blocking assignment (lvalue = #delay const).
- Armed by a start pulse. Checks three things:
  - the monitored value does not already equal the expected constant when armed;
  - it reaches that constant within a bounded number of clocks;
  - it then holds it for a minimum number of clocks.
- Reports pass/fail with a cause code and the measured latency, so benches compare against a golden latency instead of hand-coded # waits.

Parameters:
- WIDTH, 4, bit width of the monitored value
- EXPECT, 4'h5, value the monitored register must settle to (WIDTH bits)
- TIMEOUT, 15, max clocks from arm to first match; 1..255
- STABLE, 2, consecutive matching clocks required after first match; 1..15

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle arm pulse; ignored while busy
- value  in  WIDTH  monitored register
- busy  out  1  high from the cycle after start until the verdict
- done  out  1  one-cycle pulse when the verdict is issued
- pass  out  1  sticky verdict: settled and stable
- fail  out  1  sticky verdict: check failed
- fail_code  out  2  0 none, 1 early match, 2 timeout, 3 glitch (left EXPECT before STABLE)
- latency  out  8  clocks from arm to first match; sticky until next start

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; busy, done, pass, fail = 0; fail_code=0; latency=0; counters=0.
- States: IDLE, ARM, WAIT, HOLD, DONE.
- IDLE:
  - start=1 → ARM.
  - pass, fail, fail_code and latency are cleared on that edge.
- ARM (one cycle, busy=1):
  - value==EXPECT → DONE, fail=1, code=1.
  - Otherwise → WAIT, wait_cnt=1.
- WAIT:
  - value==EXPECT → HOLD; latency=wait_cnt; hold_cnt=1.
  - Else if wait_cnt==TIMEOUT → DONE, fail=1, code=2, latency=8'hFF.
  - Else wait_cnt+1.
- HOLD:
  - value!=EXPECT → DONE, fail=1, code=3.
  - Else if hold_cnt==STABLE → DONE, pass=1.
  - Else hold_cnt+1.
- DONE: done=1 for exactly this cycle, busy=0, next state IDLE.
- Compare semantics:
  - Uses !=/== with known values only.
  - An X/Z bit in value compares as mismatch: in ARM it counts as not-early; in HOLD it is a glitch.
- Widths:
  - wait_cnt is 8 bits; hold_cnt is 4 bits.
  - Counters saturate, never wrap, within the legal parameter range.
- Simultaneous events:
  - start during busy or DONE is ignored (no re-arm, no error).
  - start in the IDLE cycle immediately after DONE is accepted.
- Reset mid-check: immediate return to IDLE with all outputs 0; no done pulse.
- STABLE=1: pass is issued on the first HOLD cycle if value still matches.
- Verdict latency: best case 4 clocks after start (ARM, WAIT match, HOLD, DONE).

Decomposition:
- Shared package settle_pkg holds:
  - state encoding constants (IDLE=0, ARM=1, WAIT=2, HOLD=3, DONE=4);
  - fail-code constants FC_NONE, FC_EARLY, FC_TIMEOUT, FC_GLITCH;
  - the LAT_TIMEOUT=8'hFF sentinel.
- One natural sub-module: sat_counter (parameterised width and limit; clear, inc, at_limit outputs), instantiated twice for wait_cnt and hold_cnt.

Test Plan:
- Reset held 3 clocks, then released → all outputs 0, busy 0, state IDLE; async assert mid-cycle clears outputs without a clock edge.
- value=0, start; value←4'h5 on the 3rd clock after start, held → latency=3, pass=1, fail=0, done pulses once.
- value already 4'h5 at start → next cycle done=1, fail=1, fail_code=1, pass=0.
- value stays 4'h0 → after 15 WAIT clocks: fail=1, fail_code=2, latency=8'hFF.
- value goes to 4'h5 for 1 clock then 4'h4 (STABLE=2) → fail=1, fail_code=3, latency records the match cycle; a second start during busy is ignored, verified by a single done pulse.
- Reset asserted while in HOLD → outputs 0 immediately, no done; a subsequent start runs a clean check to pass.
